// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding the FreqWord input of a dds.
// Steps a frequency word from a start word to a stop word with a programmable dwell per word.
// Supports single sweep, repeating sawtooth and continuous triangle modes.

module dds_sweep_ctrl #(
    parameter int unsigned        PHASE_W = 32,
    parameter int unsigned        DWELL_W = 16,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [PHASE_W-1:0] PARK_FW = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] cfg_start,
    input  logic [PHASE_W-1:0] cfg_stop,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic [PHASE_W-1:0] freq_word,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sweep_cnt
);

    typedef enum logic [1:0] {StIdle, StUp, StDown, StDone} state_e;

    state_e             state_q;
    logic [PHASE_W-1:0] freq_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;

    // Configuration captured at start; later cfg_* changes do not disturb a running sweep.
    logic [PHASE_W-1:0] start_q;
    logic [PHASE_W-1:0] stop_q;
    logic [PHASE_W-1:0] step_q;
    logic [DWELL_W-1:0] dwell_cfg_q;
    logic [1:0]         mode_q;

    logic [PHASE_W:0]   up_sum;
    logic               up_hit;
    logic [PHASE_W-1:0] up_next;
    logic [PHASE_W:0]   dn_diff;
    logic               dn_hit;
    logic [PHASE_W-1:0] dn_next;
    logic               degen;
    logic               expired;
    logic [CNT_W-1:0]   cnt_inc;

    // Step arithmetic, clamped so the word never overshoots stop/start and never wraps.
    always_comb begin
        up_sum  = {1'b0, freq_q} + {1'b0, step_q};
        up_hit  = (up_sum >= {1'b0, stop_q});
        up_next = up_hit ? stop_q : up_sum[PHASE_W-1:0];
        dn_diff = {1'b0, freq_q} - {1'b0, step_q};
        dn_hit  = dn_diff[PHASE_W] || (dn_diff[PHASE_W-1:0] <= start_q);
        dn_next = dn_hit ? start_q : dn_diff[PHASE_W-1:0];
        degen   = (step_q == '0) || (start_q >= stop_q);
        expired = (dwell_q == '0);
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Sweep FSM with registered outputs; abort overrides everything, including dwell expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            freq_q      <= PARK_FW;
            dwell_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_cfg_q <= '0;
            mode_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                freq_q  <= PARK_FW;
                dwell_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            start_q     <= cfg_start;
                            stop_q      <= cfg_stop;
                            step_q      <= cfg_step;
                            dwell_cfg_q <= cfg_dwell;
                            mode_q      <= cfg_mode;
                            freq_q      <= cfg_start;
                            dwell_q     <= cfg_dwell;
                            busy_q      <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= StUp;
                        end
                    end
                    StUp: begin
                        if (!expired) begin
                            dwell_q <= dwell_q - DWELL_W'(1);
                        end else if (degen) begin
                            // Degenerate config: one dwell at start, counted as one pass.
                            cnt_q   <= CNT_W'(1);
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (freq_q == stop_q) begin
                            if (mode_q == 2'd1) begin
                                freq_q  <= start_q;
                                dwell_q <= dwell_cfg_q;
                            end else if (mode_q == 2'd2) begin
                                freq_q  <= dn_next;
                                dwell_q <= dwell_cfg_q;
                                state_q <= StDown;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end
                        end else begin
                            freq_q  <= up_next;
                            dwell_q <= dwell_cfg_q;
                            if (up_hit) begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end
                    StDown: begin
                        if (!expired) begin
                            dwell_q <= dwell_q - DWELL_W'(1);
                        end else if (freq_q == start_q) begin
                            freq_q  <= up_next;
                            dwell_q <= dwell_cfg_q;
                            state_q <= StUp;
                            if (up_hit) begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            freq_q  <= dn_next;
                            dwell_q <= dwell_cfg_q;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign freq_word = freq_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sweep_cnt = cnt_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with hand-computed expected word sequences.

module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_start;
    logic [31:0] cfg_stop;
    logic [31:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [31:0] freq_word;
    logic        busy;
    logic        done;
    logic [7:0]  sweep_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    dds_sweep_ctrl #(
        .PHASE_W (32),
        .DWELL_W (16),
        .CNT_W   (8),
        .PARK_FW (32'd0)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cfg_mode  (cfg_mode),
        .freq_word (freq_word),
        .busy      (busy),
        .done      (done),
        .sweep_cnt (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                          input logic [15:0] dw, input logic [1:0] m);
        cfg_start = s;
        cfg_stop  = e;
        cfg_step  = st;
        cfg_dwell = dw;
        cfg_mode  = m;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Word must stay at 'word' with busy high for n cycles.
    task automatic expect_run(input string tag, input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_word"}, freq_word, word);
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_done"}, {31'd0, done}, 32'd0);
            tick();
        end
    endtask

    task automatic expect_done(input string tag, input logic [31:0] word, input logic [7:0] cnt);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, "_end_word"}, freq_word, word);
        check({tag, "_cnt"}, {24'd0, sweep_cnt}, {24'd0, cnt});
        tick();
        check({tag, "_done_clear"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] t1_words [5];
    logic [31:0] t3_words [10];
    logic [7:0]  t3_cnts  [10];
    logic [1:0]  t5_modes [4];
    logic [31:0] t5_steps [4];
    logic [31:0] t5_stops [4];

    initial begin
        t1_words = '{32'd1000, 32'd1003, 32'd1006, 32'd1009, 32'd1010};
        t3_words = '{32'd10, 32'd14, 32'd18, 32'd20, 32'd16, 32'd12, 32'd10, 32'd14, 32'd18, 32'd20};
        t3_cnts  = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
        t5_modes = '{2'd0, 2'd1, 2'd2, 2'd2};
        t5_steps = '{32'd1, 32'd1, 32'd1, 32'd0};
        t5_stops = '{32'd500, 32'd500, 32'd500, 32'd600};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_start = '0;
        cfg_stop  = '0;
        cfg_step  = '0;
        cfg_dwell = '0;
        cfg_mode  = '0;
        #3;
        check("rst_word", freq_word, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cnt", {24'd0, sweep_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // T1: single sweep with dwell 1, clamped last step.
        launch(32'd1000, 32'd1010, 32'd3, 16'd1, 2'd0);
        check("t1_cnt_start", {24'd0, sweep_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) expect_run("t1", t1_words[i], 2);
        expect_done("t1", 32'd1010, 8'd1);

        // T2: near top of range, must saturate at stop without wrapping.
        launch(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0, 2'd0);
        expect_run("t2_a", 32'hFFFF_FF00, 1);
        expect_run("t2_b", 32'hFFFF_FF80, 1);
        expect_run("t2_c", 32'hFFFF_FFFF, 1);
        expect_done("t2", 32'hFFFF_FFFF, 8'd1);

        // T3: triangle, count increments on each arrival at stop.
        launch(32'd10, 32'd20, 32'd4, 16'd0, 2'd2);
        for (int i = 0; i < 10; i++) begin
            check("t3_word", freq_word, t3_words[i]);
            check("t3_cnt", {24'd0, sweep_cnt}, {24'd0, t3_cnts[i]});
            check("t3_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        check("t3_down_again", freq_word, 32'd16);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_abort_word", freq_word, 32'd0);
        check("t3_abort_busy", {31'd0, busy}, 32'd0);
        check("t3_abort_cnt", {24'd0, sweep_cnt}, 32'd2);
        tick();

        // T4: sawtooth; start pulses mid-run with new cfg are ignored; abort mid-dwell.
        launch(32'd100, 32'd110, 32'd5, 16'd2, 2'd1);
        expect_run("t4_100", 32'd100, 1);
        start = 1'b1;
        cfg_start = 32'd7;
        cfg_stop  = 32'd9;
        cfg_step  = 32'd1;
        cfg_dwell = 16'd0;
        cfg_mode  = 2'd0;
        expect_run("t4_100", 32'd100, 2);
        start = 1'b0;
        expect_run("t4_105", 32'd105, 3);
        expect_run("t4_110", 32'd110, 3);
        expect_run("t4_wrap", 32'd100, 3);
        check("t4_mid_word", freq_word, 32'd105);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_word", freq_word, 32'd0);
        check("t4_abort_busy", {31'd0, busy}, 32'd0);
        check("t4_abort_cnt", {24'd0, sweep_cnt}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t4_no_done", {31'd0, done}, 32'd0);
            tick();
        end

        // Abort asserted in the same cycle as start wins.
        cfg_start = 32'd42;
        cfg_stop  = 32'd50;
        cfg_step  = 32'd1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", {31'd0, busy}, 32'd0);
        check("abort_start_word", freq_word, 32'd0);
        tick();

        // T5: degenerate configs hold start for one dwell then finish, in every mode.
        for (int k = 0; k < 4; k++) begin
            launch(32'd500, t5_stops[k], t5_steps[k], 16'd3, t5_modes[k]);
            check("t5_cnt_start", {24'd0, sweep_cnt}, 32'd0);
            expect_run("t5", 32'd500, 4);
            expect_done("t5", 32'd500, 8'd1);
        end

        // T6: asynchronous reset between edges, then a clean restart.
        launch(32'd1000, 32'd1010, 32'd3, 16'd0, 2'd1);
        expect_run("t6_pre", 32'd1000, 1);
        expect_run("t6_pre", 32'd1003, 1);
        expect_run("t6_pre", 32'd1006, 1);
        expect_run("t6_pre", 32'd1009, 1);
        check("t6_pre_word", freq_word, 32'd1010);
        check("t6_pre_cnt", {24'd0, sweep_cnt}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_word", freq_word, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        check("t6_rst_cnt", {24'd0, sweep_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_idle_busy", {31'd0, busy}, 32'd0);
        launch(32'd1000, 32'd1010, 32'd3, 16'd0, 2'd0);
        check("t6_restart_cnt", {24'd0, sweep_cnt}, 32'd0);
        expect_run("t6_restart", 32'd1000, 1);
        expect_run("t6_restart", 32'd1003, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
